// File: rtl/vga_timing_pkg.sv
// Default 640x480 @ 60 Hz raster constants and shared coordinate helpers.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Totals on either axis must fit in this width.
  localparam int unsigned CoordW = 10;

  typedef logic [CoordW-1:0] coord_t;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active-low sync.
// 'active' describes the count about to be loaded, so the parent can register it in step.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FP      = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BP      = 48
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              advance,
  output logic [CoordW-1:0] count,
  output logic              active,
  output logic              sync_n,
  output logic              wrap
);

  localparam int unsigned Total = VISIBLE + FP + SYNC + BP;

  localparam coord_t Last      = coord_t'(Total - 1);
  localparam coord_t VisEnd    = coord_t'(VISIBLE);
  localparam coord_t SyncStart = coord_t'(VISIBLE + FP);
  localparam coord_t SyncEnd   = coord_t'(VISIBLE + FP + SYNC);

  coord_t count_q, count_d;
  logic   sync_n_q, sync_n_d;

  assign wrap = advance && (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (advance) begin
      count_d = (count_q == Last) ? '0 : count_q + coord_t'(1);
    end
    sync_n_d = !in_window(count_d, SyncStart, SyncEnd);
  end

  // Reset parks the axis on its last position so the first free-running edge lands on 0.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      count_q  <= Last;
      sync_n_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign count  = count_q;
  assign sync_n = sync_n_q;
  assign active = count_d < VisEnd;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered DrawX/DrawY, blank, hs/vs and frame_start.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame counter output.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_timing_pkg::V_BP
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  import vga_timing_pkg::*;

  logic h_active, h_wrap;
  logic v_active, v_wrap;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP)
  ) u_h_axis (
    .vga_clk (vga_clk),
    .reset   (reset),
    .advance (1'b1),
    .count   (DrawX),
    .active  (h_active),
    .sync_n  (hs),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP)
  ) u_v_axis (
    .vga_clk (vga_clk),
    .reset   (reset),
    .advance (h_wrap),
    .count   (DrawY),
    .active  (v_active),
    .sync_n  (vs),
    .wrap    (v_wrap)
  );

  logic blank_q, blank_d;
  logic frame_start_q, frame_start_d;

  // v_wrap fires exactly on the edge that moves the raster to (0, 0).
  always_comb begin
    blank_d       = h_active && v_active;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign blank       = blank_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_count_q <= 8'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule
